// File: rtl/stream_sampler.sv
// stream_sampler: valid/ready stream decimator. Forwards one accepted sample,
// then accepts and drops the next cfg_div samples, repeating. Output side is a
// single skid-free register stage; input ready is combinational from sto_tready.
module stream_sampler #(
  parameter int unsigned SDW = 32,
  parameter int unsigned SCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SCW-1:0] cfg_div,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sti_tvalid,
  output logic           sti_tready,
  output logic [SDW-1:0] sto_tdata,
  output logic           sto_tvalid,
  input  logic           sto_tready
);

  logic [SCW-1:0] cnt_q, cnt_d;
  logic [SDW-1:0] data_q, data_d;
  logic           vld_q, vld_d;
  logic           sti_xfer;
  logic           load;

  // Input is accepted whenever the output register is empty or draining this cycle;
  // discarded samples obey the same rule so back-pressure freezes the phase counter.
  assign sti_tready = ~vld_q | sto_tready;
  assign sti_xfer   = sti_tvalid & sti_tready;
  assign load       = sti_xfer & (cnt_q == '0);

  assign sto_tdata  = data_q;
  assign sto_tvalid = vld_q;

  // Next-state: phase counter advance and output register load/drain.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (sti_xfer) begin
      // >= rather than == so a cfg_div lowered below the current phase still wraps
      cnt_d = (cnt_q >= cfg_div) ? '0 : cnt_q + 1'b1;
    end
    if (load) begin
      vld_d  = 1'b1;
      data_d = sti_tdata;
    end else if (vld_q && sto_tready) begin
      vld_d = 1'b0;
    end
  end

  // State registers with asynchronous clear; a pending output sample is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_stream_sampler.sv
// tb_stream_sampler: randomized self-checking bench for stream_sampler.
// Source/drain stream models are tasks; expected output comes from an
// arithmetic decimation model that tracks the phase across runs.
module tb_stream_sampler;

  localparam int unsigned SDW    = 32;
  localparam int unsigned SCW    = 32;
  localparam int unsigned BUDGET = 200;

  typedef logic [SDW-1:0] data_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [SCW-1:0] cfg_div;
  data_t          sti_tdata;
  logic           sti_tvalid;
  logic           sti_tready;
  data_t          sto_tdata;
  logic           sto_tvalid;
  logic           sto_tready;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned cyc    = 0;
  longint unsigned m_phase = 0;

  stream_sampler #(.SDW(SDW), .SCW(SCW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .sti_tdata  (sti_tdata),
    .sti_tvalid (sti_tvalid),
    .sti_tready (sti_tready),
    .sto_tdata  (sto_tdata),
    .sto_tvalid (sto_tvalid),
    .sto_tready (sto_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (got running, required finished)");
    $fatal(1, "global time limit expired");
  end

  // Expected output of a run: with start phase p <= div, sample i is kept iff
  // (p + i) is a multiple of (div + 1). A phase above a lowered div drops one sample first.
  task automatic predict(input data_t din[$], input longint unsigned div, output data_t exp[$]);
    longint unsigned per;
    int unsigned first;
    per   = div + 1;
    first = 0;
    exp   = {};
    if (din.size() == 0) return;
    if (m_phase > div) begin
      first   = 1;
      m_phase = 0;
    end
    for (int unsigned i = first; i < din.size(); i++)
      if ((m_phase + i - first) % per == 0) exp.push_back(din[i]);
    m_phase = (m_phase + din.size() - first) % per;
  endtask

  // Source: hold valid/data until accepted. Entered on a falling edge.
  task automatic src_trn(input data_t d, output bit ok);
    int unsigned k;
    bit hs;
    k = 0;
    hs = 1'b0;
    sti_tdata  = d;
    sti_tvalid = 1'b1;
    while (!hs && k < BUDGET) begin
      #1 hs = sti_tready;
      @(negedge clk);
      k++;
    end
    sti_tvalid = 1'b0;
    ok = hs;
  endtask

  // Drain: hold ready until a valid sample is taken. Entered on a falling edge.
  task automatic drn_trn(output data_t d, output bit ok);
    int unsigned k;
    bit hs;
    k = 0;
    hs = 1'b0;
    d = '0;
    sto_tready = 1'b1;
    while (!hs && k < BUDGET) begin
      #1 begin
        hs = sto_tvalid;
        d  = sto_tdata;
      end
      @(negedge clk);
      k++;
    end
    sto_tready = 1'b0;
    ok = hs;
  endtask

  // Push all of din through the DUT while draining exactly n_out samples.
  task automatic run_stream(input data_t din[$], input int unsigned n_out,
                            input int unsigned idle_max, output data_t got[$], output bit ok);
    bit s_ok;
    bit d_ok;
    s_ok = 1'b1;
    d_ok = 1'b1;
    got = {};
    @(negedge clk);
    fork
      begin
        bit o;
        foreach (din[i]) if (s_ok) begin
          src_trn(din[i], o);
          s_ok &= o;
        end
      end
      begin
        data_t v;
        bit o;
        for (int unsigned j = 0; j < n_out && d_ok; j++) begin
          if (idle_max > 0) repeat ($urandom_range(idle_max, 0)) @(negedge clk);
          drn_trn(v, o);
          if (o) got.push_back(v);
          d_ok &= o;
        end
      end
    join
    ok = s_ok && d_ok;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sto_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (sto_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b required 0", sto_tvalid);
    else n_pass++;
    n_chk++;
    if (sto_tdata !== '0) $display("FAIL reset_tdata: got %h required 0", sto_tdata);
    else n_pass++;
    n_chk++;
    if (sti_tready !== 1'b1) $display("FAIL reset_tready: got %b required 1", sti_tready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (sto_tvalid !== 1'b0) $display("FAIL post_reset_tvalid: got %b required 0", sto_tvalid);
    else n_pass++;
  endtask

  task automatic test_div0();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    int unsigned c0;
    for (int unsigned i = 0; i < 8; i++) din.push_back(data_t'(i));
    cfg_div = '0;
    predict(din, 0, exp);
    c0 = cyc;
    run_stream(din, exp.size(), 0, got, ok);
    n_chk++;
    if (!ok) $display("FAIL div0_handshake: got timeout required completion");
    else n_pass++;
    n_chk++;
    if (cyc - c0 > din.size() + 3) $display("FAIL div0_throughput: got %0d cycles required <= %0d", cyc - c0, din.size() + 3);
    else n_pass++;
    n_chk++;
    if (got.size() !== exp.size()) $display("FAIL div0_count: got %0d required %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL div0_data[%0d]: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_switch();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    for (int unsigned i = 0; i < 8; i++) din.push_back(data_t'(i));
    @(negedge clk);
    cfg_div = SCW'(1);
    predict(din, 1, exp);
    run_stream(din, exp.size(), 0, got, ok);
    n_chk++;
    if (!ok) $display("FAIL div1_handshake: got timeout required completion");
    else n_pass++;
    n_chk++;
    if (got.size() !== exp.size()) $display("FAIL div1_count: got %0d required %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL div1_data[%0d]: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (sto_tvalid !== 1'b0) $display("FAIL div1_no_extra: got tvalid %b required 0", sto_tvalid);
    else n_pass++;
  endtask

  task automatic test_div3();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    for (int unsigned i = 0; i < 12; i++) din.push_back(data_t'(i));
    cfg_div = SCW'(3);
    predict(din, 3, exp);
    run_stream(din, exp.size(), 0, got, ok);
    n_chk++;
    if (!ok) $display("FAIL div3_handshake: got timeout required completion");
    else n_pass++;
    n_chk++;
    if (got.size() !== exp.size()) $display("FAIL div3_count: got %0d required %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL div3_data[%0d]: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit s_ok;
    bit d_ok;
    for (int unsigned i = 0; i < 8; i++) din.push_back(data_t'(i));
    cfg_div = SCW'(1);
    predict(din, 1, exp);
    s_ok = 1'b1;
    d_ok = 1'b1;
    sto_tready = 1'b0;
    @(negedge clk);
    fork
      begin
        bit o;
        foreach (din[i]) if (s_ok) begin
          src_trn(din[i], o);
          s_ok &= o;
        end
      end
      begin
        data_t v;
        bit o;
        int unsigned k;
        k = 0;
        while (!sto_tvalid && k < BUDGET) begin
          @(negedge clk);
          k++;
        end
        if (!sto_tvalid) d_ok = 1'b0;
        repeat (5) begin
          #1;
          n_chk++;
          if (sti_tready !== 1'b0) $display("FAIL stall_tready: got %b required 0", sti_tready);
          else n_pass++;
          n_chk++;
          if (sto_tdata !== exp[0]) $display("FAIL stall_hold: got %h required %h", sto_tdata, exp[0]);
          else n_pass++;
          @(negedge clk);
        end
        for (int unsigned j = 0; j < exp.size() && d_ok; j++) begin
          drn_trn(v, o);
          if (o) got.push_back(v);
          d_ok &= o;
        end
      end
    join
    n_chk++;
    if (!(s_ok && d_ok)) $display("FAIL stall_handshake: got timeout required completion");
    else n_pass++;
    n_chk++;
    if (got.size() !== exp.size()) $display("FAIL stall_count: got %0d required %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL stall_data[%0d]: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    for (int unsigned i = 0; i < 4; i++) din.push_back(data_t'($urandom));
    cfg_div = SCW'(2);
    predict(din, 2, exp);
    // drain only the first kept sample so the second one is left pending
    run_stream(din, 1, 0, got, ok);
    n_chk++;
    if (!ok || got.size() != 1 || got[0] !== exp[0])
      $display("FAIL rstmid_first: got %0d samples (ok=%0b) required 1 sample %h", got.size(), ok, exp[0]);
    else n_pass++;
    #1;
    n_chk++;
    if (sto_tvalid !== 1'b1 || sto_tdata !== exp[1])
      $display("FAIL rstmid_pending: got valid %b data %h required valid 1 data %h", sto_tvalid, sto_tdata, exp[1]);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (sto_tvalid !== 1'b0 || sto_tdata !== '0)
      $display("FAIL rstmid_async_clear: got valid %b data %h required valid 0 data 0", sto_tvalid, sto_tdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    din = {};
    for (int unsigned i = 0; i < 6; i++) din.push_back(data_t'(i));
    predict(din, 2, exp);
    run_stream(din, exp.size(), 0, got, ok);
    n_chk++;
    if (!ok) $display("FAIL rstmid_handshake: got timeout required completion");
    else n_pass++;
    n_chk++;
    if (got.size() !== exp.size()) $display("FAIL rstmid_count: got %0d required %0d", got.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL rstmid_data[%0d]: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  // Lower cfg_div below the current phase, and run at the widest divider.
  task automatic test_div_change();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    longint unsigned divs[4];
    int unsigned lens[4];
    divs[0] = 3;  lens[0] = 2;
    divs[1] = 1;  lens[1] = 6;
    divs[2] = 64'hFFFF_FFFF; lens[2] = 8;
    divs[3] = 0;  lens[3] = 4;
    for (int r = 0; r < 4; r++) begin
      din = {};
      for (int unsigned i = 0; i < lens[r]; i++) din.push_back(data_t'($urandom));
      @(negedge clk);
      cfg_div = divs[r][SCW-1:0];
      predict(din, divs[r], exp);
      run_stream(din, exp.size(), 0, got, ok);
      n_chk++;
      if (!ok) $display("FAIL chg%0d_handshake: got timeout required completion", r);
      else n_pass++;
      n_chk++;
      if (got.size() !== exp.size()) $display("FAIL chg%0d_count: got %0d required %0d", r, got.size(), exp.size());
      else n_pass++;
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        n_chk++;
        if (got[i] !== exp[i]) $display("FAIL chg%0d_data[%0d]: got %h required %h", r, i, got[i], exp[i]);
        else n_pass++;
      end
    end
  endtask

  // Random dividers, lengths, data and drain idle gaps.
  task automatic test_random();
    data_t din[$];
    data_t exp[$];
    data_t got[$];
    bit ok;
    longint unsigned div;
    for (int r = 0; r < 6; r++) begin
      din = {};
      div = longint'($urandom_range(4, 0));
      repeat ($urandom_range(20, 1)) din.push_back(data_t'($urandom));
      @(negedge clk);
      cfg_div = div[SCW-1:0];
      predict(din, div, exp);
      run_stream(din, exp.size(), 3, got, ok);
      n_chk++;
      if (!ok) $display("FAIL rnd%0d_handshake: got timeout required completion", r);
      else n_pass++;
      n_chk++;
      if (got.size() !== exp.size()) $display("FAIL rnd%0d_count: got %0d required %0d", r, got.size(), exp.size());
      else n_pass++;
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        n_chk++;
        if (got[i] !== exp[i]) $display("FAIL rnd%0d_data[%0d]: got %h required %h", r, i, got[i], exp[i]);
        else n_pass++;
      end
      n_chk++;
      if (sto_tvalid !== 1'b0) $display("FAIL rnd%0d_no_extra: got tvalid %b required 0", r, sto_tvalid);
      else n_pass++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_div    = '0;
    sti_tdata  = '0;
    sti_tvalid = 1'b0;
    sto_tready = 1'b0;
    test_reset();
    test_div0();
    test_div_switch();
    test_div3();
    test_backpressure();
    test_reset_midstream();
    test_div_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
